axi_lite_dmem_slave: RTL and testbench
======================================

Name: axi_lite_dmem_slave

Overview:
AXI4-Lite responder, the slave end of the core's HOST data port: an on-chip word-addressed data RAM.
- Accepts write address and write data independently, in either order, with byte-strobe merge.
- Returns single-beat read and write responses.
- One outstanding transaction per direction. Read and write paths are independent FSMs sharing one memory array.

Parameters:
AXI_AWIDTH, 32, address width of all address channels
AXI_DWIDTH, 32, data width; fixed at 32 for this block (WSTRB = 4 bits)
MEM_DEPTH, 1024, number of 32-bit words; must be a power of 2
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  asynchronous, active-high reset
S_AXI_AWADDR  in  AXI_AWIDTH  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  AXI_DWIDTH  write data
S_AXI_WSTRB  in  AXI_DWIDTH/8  byte lane enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response (00 OKAY, 10 SLVERR)
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  AXI_AWIDTH  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  AXI_DWIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready

Behaviour:
Reset and addressing:
- While RST=1: AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=00, RDATA=0. All captured addresses and data are discarded.
- First rising edge after RST falls: the three READY outputs go to 1. Memory array is not reset.
- Reset mid-transaction: no partial write, no response issued.
- Index = ((ADDR - BASE_ADDR) >> 2) mod MEM_DEPTH. ADDR[1:0] is ignored; the subtraction wraps modulo 2^AXI_AWIDTH.

Write FSM, states W_IDLE and W_RESP:
- W_IDLE: AWREADY = !aw_held; WREADY = !w_held. A handshake on AW latches the address and sets aw_held; a handshake on W latches data/strobe and sets w_held. Same-cycle AW and W is legal.
- Completion cycle: the first cycle where both channels are held or handshaking. On its closing edge:
  - the write commits: byte lane i is written iff WSTRB[i]; WSTRB=0 writes nothing and responds OKAY;
  - BVALID rises and AWREADY/WREADY drop; state goes to W_RESP.
- Minimum latency: BVALID one cycle after the completing handshake.
- W_RESP: BVALID and BRESP are held stable until BREADY.
- On BVALID&&BREADY: BVALID falls, aw_held and w_held clear, READYs rise on the same edge, state goes to W_IDLE. Back-to-back writes are therefore possible every 2 cycles.

Read FSM, states R_IDLE and R_RESP:
- R_IDLE: ARREADY=1.
- On AR handshake: RDATA is registered from the array, RVALID rises and ARREADY falls on the same edge, state goes to R_RESP. Read latency is 1 cycle.
- R_RESP: RDATA, RRESP and RVALID are held until RREADY.
- On RVALID&&RREADY: RVALID falls and ARREADY rises on the same edge, state goes to R_IDLE.

Collisions and ordering:
- Read handshake on the same edge as a write commit to the same index: read returns the pre-write data (read-before-write).
- A read accepted on any later edge sees the new data.
- BVALID and RVALID are independent; simultaneous responses are legal.
- The block never deasserts a VALID before its READY handshake.

Optional Feature:
Macro DMEM_ERR_RESP_EN.
- Defined: an access with ADDR < BASE_ADDR or ADDR >= BASE_ADDR + 4*MEM_DEPTH is out of range.
  - Out-of-range write: suppressed, BRESP=10 (SLVERR).
  - Out-of-range read: RDATA=0, RRESP=10.
  - In-range accesses respond 00.
- Undefined: no range check; the index wraps modulo MEM_DEPTH and all responses are 00 (OKAY).

Test Plan:
- Reset release: RST 1->0 -> all READYs 1 one edge later; BVALID=RVALID=0. Read 0x10 -> RVALID one cycle after AR; RRESP=00.
- Write ordering: AW=0x8 leads W=0xDEADBEEF (STRB=F) by 3 cycles; then W leads AW by 2; then same-cycle AW/W -> BVALID one cycle after the last handshake each time; readback 0x8 = 0xDEADBEEF.
- Strobe merge: write 0x11223344 to 0x4, then write 0xAABBCCDD with STRB=0101 -> readback 0x11BB33DD. A write with STRB=0000 leaves 0x11BB33DD; BRESP=00.
- Backpressure: hold BREADY=0 for 5 cycles and RREADY=0 for 4 -> BVALID/BRESP and RVALID/RDATA stable; AWREADY/WREADY/ARREADY stay 0; new AR is not accepted until RREADY.
- Collision: 0x20 holds 0x1; AR 0x20 on the write-commit edge of 0x2 -> RDATA=0x1; next read -> 0x2.
- Range/wrap with MEM_DEPTH=1024, BASE=0:
  - DMEM_ERR_RESP_EN defined: write to 0x1000 -> BRESP=10, word 0 unchanged; read 0x1000 -> RDATA=0, RRESP=10.
  - Undefined: the same write lands in word 0; BRESP=00.

Source files
------------

// File: rtl/axi_lite_dmem_slave.sv
// axi_lite_dmem_slave: AXI4-Lite responder over a word-addressed data RAM; `define DMEM_ERR_RESP_EN enables out-of-range SLVERR responses
module axi_lite_dmem_slave #(
    parameter int                    AXI_AWIDTH = 32,
    parameter int                    AXI_DWIDTH = 32,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [AXI_AWIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [AXI_AWIDTH-1:0]   S_AXI_AWADDR,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [AXI_DWIDTH-1:0]   S_AXI_WDATA,
    input  logic [AXI_DWIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [AXI_AWIDTH-1:0]   S_AXI_ARADDR,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [AXI_DWIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY
);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam int SW = AXI_DWIDTH / 8;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state, w_state_nx;
    r_state_t r_state, r_state_nx;

    logic                  up, aw_held, w_held;
    logic [AXI_AWIDTH-1:0] aw_addr, w_off, r_off;
    logic [AXI_DWIDTH-1:0] w_data, wdata_sel, rdata_q;
    logic [SW-1:0]         w_strb, wstrb_sel;
    logic [1:0]            bresp_q, rresp_q;
    logic [IW-1:0]         w_idx, r_idx;
    logic                  aw_hs, w_hs, ar_hs, commit, wr_en;
    logic                  w_oor, r_oor, w_err, r_err, unused_bits;
    logic [AXI_DWIDTH-1:0] mem [MEM_DEPTH];

    assign S_AXI_AWREADY = up && w_state == W_IDLE && !aw_held;
    assign S_AXI_WREADY  = up && w_state == W_IDLE && !w_held;
    assign S_AXI_BVALID  = w_state == W_RESP;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = up && r_state == R_IDLE;
    assign S_AXI_RVALID  = r_state == R_RESP;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    // A held beat takes priority over the bus so completion works in either arrival order
    assign w_off     = (aw_held ? aw_addr : S_AXI_AWADDR) - BASE_ADDR;
    assign r_off     = S_AXI_ARADDR - BASE_ADDR;
    assign wdata_sel = w_held ? w_data : S_AXI_WDATA;
    assign wstrb_sel = w_held ? w_strb : S_AXI_WSTRB;
    assign w_idx     = w_off[IW+1:2];
    assign r_idx     = r_off[IW+1:2];
    assign w_oor     = |w_off[AXI_AWIDTH-1:IW+2];
    assign r_oor     = |r_off[AXI_AWIDTH-1:IW+2];

`ifdef DMEM_ERR_RESP_EN
    assign w_err       = w_oor;
    assign r_err       = r_oor;
    assign unused_bits = ^{w_off[1:0], r_off[1:0]};
`else
    assign w_err       = 1'b0;
    assign r_err       = 1'b0;
    assign unused_bits = ^{w_off[1:0], r_off[1:0], w_oor, r_oor};
`endif

    // Write FSM next state: commit on the first cycle both AW and W are held or handshaking
    always_comb begin
        aw_hs      = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs       = S_AXI_WVALID && S_AXI_WREADY;
        commit     = w_state == W_IDLE && (aw_held || aw_hs) && (w_held || w_hs);
        wr_en      = commit && !w_err;
        w_state_nx = commit ? W_RESP : (w_state == W_RESP && S_AXI_BREADY) ? W_IDLE : w_state;
    end

    // Read FSM next state: accept one address, hold the response until RREADY
    always_comb begin
        ar_hs      = S_AXI_ARVALID && S_AXI_ARREADY;
        r_state_nx = ar_hs ? R_RESP : (r_state == R_RESP && S_AXI_RREADY) ? R_IDLE : r_state;
    end

    // Write state register, beat capture and response code
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_state <= W_IDLE;
            up      <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bresp_q <= 2'b00;
        end else begin
            up      <= 1'b1;
            w_state <= w_state_nx;
            if (w_state == W_RESP && S_AXI_BREADY) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_held <= 1'b1;
                    aw_addr <= S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_held <= 1'b1;
                    w_data <= S_AXI_WDATA;
                    w_strb <= S_AXI_WSTRB;
                end
            end
            if (commit) bresp_q <= w_err ? 2'b10 : 2'b00;
        end
    end

    // Read state register; the array is sampled before this edge's write lands
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= 2'b00;
        end else begin
            r_state <= r_state_nx;
            if (ar_hs) begin
                rdata_q <= r_err ? '0 : mem[r_idx];
                rresp_q <= r_err ? 2'b10 : 2'b00;
            end
        end
    end

    // Byte-lane merge into the array; contents survive reset
    always_ff @(posedge CLK) begin
        for (int i = 0; i < SW; i++)
            if (wr_en && wstrb_sel[i]) mem[w_idx][8*i +: 8] <= wdata_sel[8*i +: 8];
    end
endmodule

// File: tb/tb_axi_lite_dmem_slave.sv
// tb_axi_lite_dmem_slave: directed and randomized traffic checked each cycle against a transaction-level memory model
module tb_axi_lite_dmem_slave;
    localparam logic [31:0] BASE  = 32'h0;
    localparam int          DEPTH = 1024;
`ifdef DMEM_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b0;
    logic [31:0] aw_addr = '0, w_data = '0, ar_addr = '0;
    logic [3:0]  w_strb = '0;
    logic aw_valid = 1'b0, w_valid = 1'b0, ar_valid = 1'b0, b_ready = 1'b1, r_ready = 1'b1;
    logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic [1:0]  b_resp, r_resp;
    logic [31:0] r_data;
    int checks = 0, failures = 0;
    bit rnd_rdy = 1'b0;

    axi_lite_dmem_slave dut (
        .CLK(clk), .RST(rst),
        .S_AXI_AWADDR(aw_addr), .S_AXI_AWVALID(aw_valid), .S_AXI_AWREADY(aw_ready),
        .S_AXI_WDATA(w_data), .S_AXI_WSTRB(w_strb), .S_AXI_WVALID(w_valid), .S_AXI_WREADY(w_ready),
        .S_AXI_BRESP(b_resp), .S_AXI_BVALID(b_valid), .S_AXI_BREADY(b_ready),
        .S_AXI_ARADDR(ar_addr), .S_AXI_ARVALID(ar_valid), .S_AXI_ARREADY(ar_ready),
        .S_AXI_RDATA(r_data), .S_AXI_RRESP(r_resp), .S_AXI_RVALID(r_valid), .S_AXI_RREADY(r_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        failures++;
        $display("FAIL %s: no handshake within 200 cycles, required one at %0t", name, $time);
    endtask

    function automatic int unsigned idx_of(input logic [31:0] a);
        return ((a - BASE) >> 2) % DEPTH;
    endfunction

    function automatic bit oor(input logic [31:0] a);
        return ERR_EN && ((a - BASE) >= 32'(4 * DEPTH));
    endfunction

    // Model: word array plus pending-beat and outstanding-response flags
    logic [31:0] mm [DEPTH];
    bit          known [DEPTH];
    bit          m_up, m_b, m_r, m_rknown, m_aw_p, m_w_p;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_rdata, m_aw_a, m_w_d;
    logic [3:0]  m_w_s;

    // Compare outputs every cycle, then advance the model across the coming edge
    always @(negedge clk) begin
        bit e_awr, e_wr, e_arr, aw_hs, w_hs, ar_hs;
        int unsigned k;
        if (rst) begin
            chk("rst_outputs", {aw_ready, w_ready, ar_ready, b_valid, r_valid, b_resp, r_resp}, 32'h0);
            chk("rst_rdata", r_data, 32'h0);
            m_up = 0; m_b = 0; m_r = 0; m_aw_p = 0; m_w_p = 0;
        end else begin
            e_awr = m_up && !m_b && !m_aw_p;
            e_wr  = m_up && !m_b && !m_w_p;
            e_arr = m_up && !m_r;
            chk("awready", aw_ready, e_awr);
            chk("wready", w_ready, e_wr);
            chk("arready", ar_ready, e_arr);
            chk("bvalid", b_valid, m_b);
            chk("rvalid", r_valid, m_r);
            if (m_b) chk("bresp", b_resp, m_bresp);
            if (m_r) begin
                chk("rresp", r_resp, m_rresp);
                if (m_rknown) chk("rdata", r_data, m_rdata);
            end
            aw_hs = aw_valid && e_awr;
            w_hs  = w_valid && e_wr;
            ar_hs = ar_valid && e_arr;
            if (m_b && b_ready) m_b = 0;
            if (m_r && r_ready) m_r = 0;
            if (ar_hs) begin
                k = idx_of(ar_addr);
                m_r = 1;
                m_rresp  = oor(ar_addr) ? 2'b10 : 2'b00;
                m_rdata  = oor(ar_addr) ? 32'h0 : mm[k];
                m_rknown = oor(ar_addr) || known[k];
            end
            if (aw_hs) begin m_aw_p = 1; m_aw_a = aw_addr; end
            if (w_hs) begin m_w_p = 1; m_w_d = w_data; m_w_s = w_strb; end
            if (m_aw_p && m_w_p) begin
                m_aw_p = 0; m_w_p = 0; m_b = 1;
                m_bresp = oor(m_aw_a) ? 2'b10 : 2'b00;
                if (!oor(m_aw_a)) begin
                    k = idx_of(m_aw_a);
                    for (int i = 0; i < 4; i++) if (m_w_s[i]) mm[k][8*i +: 8] = m_w_d[8*i +: 8];
                    if (m_w_s == 4'hF) known[k] = 1;
                end
            end
            m_up = 1;
        end
    end

    // Random response backpressure during the random phase
    initial forever begin
        @(posedge clk); #1;
        if (rnd_rdy) begin
            b_ready = ($urandom % 4) != 0;
            r_ready = ($urandom % 4) != 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required TB_RESULT earlier");
        $fatal(1, "watchdog");
    end

    task automatic do_aw(input logic [31:0] a);
        int n = 0;
        aw_addr = a; aw_valid = 1;
        @(negedge clk);
        while (!aw_ready && n < 200) begin n++; @(negedge clk); end
        if (!aw_ready) tmo("aw_wait");
        @(posedge clk); #1 aw_valid = 0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        w_data = d; w_strb = s; w_valid = 1;
        @(negedge clk);
        while (!w_ready && n < 200) begin n++; @(negedge clk); end
        if (!w_ready) tmo("w_wait");
        @(posedge clk); #1 w_valid = 0;
    endtask

    task automatic do_ar(input logic [31:0] a);
        int n = 0;
        ar_addr = a; ar_valid = 1;
        @(negedge clk);
        while (!ar_ready && n < 200) begin n++; @(negedge clk); end
        if (!ar_ready) tmo("ar_wait");
        @(posedge clk); #1 ar_valid = 0;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        while (!(b_valid && b_ready) && n < 200) begin n++; @(negedge clk); end
        if (!(b_valid && b_ready)) tmo("b_wait");
        resp = b_resp;
        @(posedge clk); #1;
    endtask

    task automatic wait_r(output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        while (!(r_valid && r_ready) && n < 200) begin n++; @(negedge clk); end
        if (!(r_valid && r_ready)) tmo("r_wait");
        d = r_data; resp = r_resp;
        @(posedge clk); #1;
    endtask

    task automatic do_write_gap(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                input int ga, input int gw, output logic [1:0] br);
        fork
            begin repeat (ga) begin @(posedge clk); #1; end do_aw(a); end
            begin repeat (gw) begin @(posedge clk); #1; end do_w(d, s); end
        join
        wait_b(br);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] br);
        do_write_gap(a, d, s, 0, 0, br);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] rr);
        do_ar(a);
        wait_r(d, rr);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned sel = $urandom_range(0, 7);
        logic [31:0] a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
        if (sel == 0) a += 32'h1000 * $urandom_range(1, 3);
        else if (sel == 1) a += 32'hFFFF_F000;
        return a;
    endfunction

    initial begin
        logic [31:0] d, wa, ra, wd;
        logic [3:0]  ws;
        logic [1:0]  br, rr;
        int op, ga, gw;
        #1 rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk); chk("ready_before_edge", {aw_ready, w_ready, ar_ready}, 32'h0);
        @(negedge clk); chk("ready_after_edge", {aw_ready, w_ready, ar_ready}, 32'h7);
        @(posedge clk); #1;
        do_read(32'h10, d, rr);
        chk("first_read_rresp", rr, 2'b00);

        do_write_gap(32'h8, 32'h1234_5678, 4'hF, 0, 3, br);
        chk("aw_first_bresp", br, 2'b00);
        do_write_gap(32'h8, 32'hCAFE_F00D, 4'hF, 2, 0, br);
        do_write(32'h8, 32'hDEAD_BEEF, 4'hF, br);
        do_read(32'h8, d, rr);
        chk("readback_8", d, 32'hDEAD_BEEF);

        do_write(32'h4, 32'h1122_3344, 4'hF, br);
        do_write(32'h4, 32'hAABB_CCDD, 4'b0101, br);
        do_read(32'h4, d, rr);
        chk("strobe_merge", d, 32'h11BB_33DD);
        do_write(32'h4, 32'hFFFF_FFFF, 4'b0000, br);
        chk("strb0_bresp", br, 2'b00);
        do_read(32'h4, d, rr);
        chk("strb0_keeps", d, 32'h11BB_33DD);

        b_ready = 0; r_ready = 0;
        fork
            do_aw(32'h30);
            do_w(32'h55AA_55AA, 4'hF);
            do_ar(32'h4);
        join
        fork
            do_ar(32'h8);
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("bp_rdata_stable", r_data, 32'h11BB_33DD);
                    chk("bp_bvalid_held", b_valid, 1'b1);
                    chk("bp_no_new_ar", ar_ready, 1'b0);
                end
                @(posedge clk); #1 r_ready = 1;
                @(negedge clk); chk("bp_b_still_held", {b_valid, b_resp}, 3'b100);
                @(posedge clk); #1 b_ready = 1;
            end
        join
        wait_r(d, rr);
        chk("bp_queued_read", d, 32'hDEAD_BEEF);

        do_write(32'h20, 32'h1, 4'hF, br);
        fork
            do_aw(32'h20);
            do_w(32'h2, 4'hF);
            do_ar(32'h20);
        join
        wait_r(d, rr);
        chk("collision_old", d, 32'h1);
        do_read(32'h20, d, rr);
        chk("collision_new", d, 32'h2);

        do_write(32'h0, 32'hA5A5_A5A5, 4'hF, br);
        do_write(32'h1000, 32'h5A5A_5A5A, 4'hF, br);
        chk("range_bresp", br, ERR_EN ? 2'b10 : 2'b00);
        do_read(32'h1000, d, rr);
        chk("range_rdata", d, ERR_EN ? 32'h0 : 32'h5A5A_5A5A);
        chk("range_rresp", rr, ERR_EN ? 2'b10 : 2'b00);
        do_read(32'h0, d, rr);
        chk("range_word0", d, ERR_EN ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A);

        do_aw(32'h40);
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        do_w(32'h77, 4'hF);
        repeat (3) begin @(negedge clk); chk("no_b_after_reset", b_valid, 1'b0); end
        @(posedge clk); #1;
        do_aw(32'h44);
        wait_b(br);
        do_read(32'h44, d, rr);
        chk("post_reset_write", d, 32'h77);
        do_read(32'h20, d, rr);
        chk("mem_survives_reset", d, 32'h2);

        for (int k = 0; k < 64; k++) do_write(32'(k * 4), $urandom, 4'hF, br);
        rnd_rdy = 1;
        repeat (200) begin
            op = $urandom_range(0, 2);
            wa = rand_addr(); ra = rand_addr(); wd = $urandom; ws = 4'($urandom);
            ga = $urandom_range(0, 3); gw = $urandom_range(0, 3);
            if ($urandom % 4 == 0) ra = wa;
            if (op == 0) do_write_gap(wa, wd, ws, ga, gw, br);
            else if (op == 1) do_read(ra, d, rr);
            else fork
                do_write_gap(wa, wd, ws, ga, gw, br);
                do_read(ra, d, rr);
            join
        end
        rnd_rdy = 0; b_ready = 1; r_ready = 1;
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
